// File: rtl/riscv_alu_md_pkg.sv
// Shared codes for the EX-stage ALU and the iterative RV32M unit.
package riscv_alu_md_pkg;

  localparam logic [2:0] ALUOP_ADD = 3'b000;
  localparam logic [2:0] ALUOP_SUB = 3'b001;
  localparam logic [2:0] ALUOP_R   = 3'b010;
  localparam logic [2:0] ALUOP_I   = 3'b011;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SLL  = 4'h1;
  localparam logic [3:0] ALU_SLT  = 4'h2;
  localparam logic [3:0] ALU_SLTU = 4'h3;
  localparam logic [3:0] ALU_XOR  = 4'h4;
  localparam logic [3:0] ALU_SRL  = 4'h5;
  localparam logic [3:0] ALU_OR   = 4'h6;
  localparam logic [3:0] ALU_AND  = 4'h7;
  localparam logic [3:0] ALU_SUB  = 4'h8;
  localparam logic [3:0] ALU_SRA  = 4'hD;

  localparam logic [2:0] BR_EQ  = 3'd0;
  localparam logic [2:0] BR_NE  = 3'd1;
  localparam logic [2:0] BR_LT  = 3'd4;
  localparam logic [2:0] BR_GE  = 3'd5;
  localparam logic [2:0] BR_LTU = 3'd6;
  localparam logic [2:0] BR_GEU = 3'd7;

  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  typedef enum logic [1:0] {IDLE, CALC, DONE} md_state_e;

  function automatic logic md_a_signed(input logic [2:0] op);
    return op == MD_MUL || op == MD_MULH || op == MD_MULHSU || op == MD_DIV || op == MD_REM;
  endfunction

  function automatic logic md_b_signed(input logic [2:0] op);
    return op == MD_MUL || op == MD_MULH || op == MD_DIV || op == MD_REM;
  endfunction

endpackage

// File: rtl/riscv_muldiv_iter.sv
// Radix-2 iterative multiply/divide: sign-magnitude operands, shift-add multiply,
// restoring divide, one step per cycle, sign fix-up in DONE.
module riscv_muldiv_iter
  import riscv_alu_md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] result
);
  localparam int CW = $clog2(WIDTH) + 1;

  md_state_e          state, state_nx;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc, prod;
  logic [WIDTH-1:0]   opd, a_orig, mag_a, mag_b, quot, remv, res_c;
  logic [WIDTH:0]     msum, rs, diff;
  logic [2:0]         op_q;
  logic               neg_a, neg_b, sa, sb, accept, bz;

  assign busy   = (state != IDLE);
  assign accept = (state == IDLE) && start && !flush;
  assign sa     = md_a_signed(op) & a[WIDTH-1];
  assign sb     = md_b_signed(op) & b[WIDTH-1];
  assign mag_a  = sa ? -a : a;
  assign mag_b  = sb ? -b : b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = CALC;
      CALC:    if (cnt == CW'(1)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  // opd holds the multiplicand for multiply, the divisor magnitude for divide
  assign msum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opd} : '0);
  assign rs   = acc[2*WIDTH-1:WIDTH-1];
  assign diff = rs - {1'b0, opd};

  assign prod = (neg_a ^ neg_b) ? -acc : acc;
  assign quot = (neg_a ^ neg_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign remv = neg_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  assign bz   = (opd == '0);

  always_comb begin
    res_c = '0;
    case (op_q)
      MD_MUL:                     res_c = prod[WIDTH-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: res_c = prod[2*WIDTH-1:WIDTH];
      MD_DIV, MD_DIVU:            res_c = bz ? '1 : quot;
      default:                    res_c = bz ? a_orig : remv;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      acc    <= '0;
      opd    <= '0;
      a_orig <= '0;
      op_q   <= '0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      valid  <= 1'b0;
      result <= '0;
    end else begin
      valid <= 1'b0;
      if (accept) begin
        op_q   <= op;
        neg_a  <= sa;
        neg_b  <= sb;
        a_orig <= a;
        cnt    <= CW'(WIDTH);
        acc    <= {{WIDTH{1'b0}}, op[2] ? mag_a : mag_b};
        opd    <= op[2] ? mag_b : mag_a;
      end else if (state == CALC && !flush) begin
        cnt <= cnt - CW'(1);
        if (!op_q[2])     acc <= {msum, acc[WIDTH-1:1]};
        else if (diff[WIDTH]) acc <= {rs[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        else              acc <= {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else if (state == DONE && !flush) begin
        valid  <= 1'b1;
        result <= res_c;
      end
    end
  end

endmodule

// File: rtl/riscv_alu_md.sv
// EX-stage ALU: combinational RV32I ALU and branch compare, plus the iterative mul/div unit.
module riscv_alu_md
  import riscv_alu_md_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [3:0]       func,
  input  logic [2:0]       aluOp,
  input  logic             mdStart,
  input  logic [2:0]       mdOp,
  input  logic             flush,
  output logic [WIDTH-1:0] aluResult,
  output logic             branchFromAlu,
  output logic             busy,
  output logic             mdValid,
  output logic [WIDTH-1:0] mdResult
);
  logic [3:0]         fsel;
  logic [SHAMT_W-1:0] shamt;
  logic               lt_s, lt_u;

  assign shamt = dataB[SHAMT_W-1:0];
  assign lt_s  = $signed(dataA) < $signed(dataB);
  assign lt_u  = dataA < dataB;

  // immediates carry no SUB; bit 3 only distinguishes SRAI from SRLI
  assign fsel = (aluOp == ALUOP_I) ? {func[3] & (func[2:0] == 3'd5), func[2:0]} : func;

  always_comb begin
    aluResult = '0;
    case (aluOp)
      ALUOP_ADD: aluResult = dataA + dataB;
      ALUOP_SUB: aluResult = dataA - dataB;
      ALUOP_R, ALUOP_I: begin
        case (fsel)
          ALU_ADD:  aluResult = dataA + dataB;
          ALU_SUB:  aluResult = dataA - dataB;
          ALU_SLL:  aluResult = dataA << shamt;
          ALU_SLT:  aluResult = {{(WIDTH-1){1'b0}}, lt_s};
          ALU_SLTU: aluResult = {{(WIDTH-1){1'b0}}, lt_u};
          ALU_XOR:  aluResult = dataA ^ dataB;
          ALU_SRL:  aluResult = dataA >> shamt;
          ALU_SRA:  aluResult = WIDTH'($signed(dataA) >>> shamt);
          ALU_OR:   aluResult = dataA | dataB;
          ALU_AND:  aluResult = dataA & dataB;
          default:  aluResult = '0;
        endcase
      end
      default: aluResult = '0;
    endcase
  end

  always_comb begin
    branchFromAlu = 1'b0;
    case (func[2:0])
      BR_EQ:   branchFromAlu = (dataA == dataB);
      BR_NE:   branchFromAlu = (dataA != dataB);
      BR_LT:   branchFromAlu = lt_s;
      BR_GE:   branchFromAlu = !lt_s;
      BR_LTU:  branchFromAlu = lt_u;
      BR_GEU:  branchFromAlu = !lt_u;
      default: branchFromAlu = 1'b0;
    endcase
  end

  riscv_muldiv_iter #(.WIDTH(WIDTH)) u_md (
    .clk    (clk),
    .reset  (reset),
    .start  (mdStart),
    .op     (mdOp),
    .a      (dataA),
    .b      (dataB),
    .flush  (flush),
    .busy   (busy),
    .valid  (mdValid),
    .result (mdResult)
  );

endmodule

// File: tb/tb_riscv_alu_md.sv
// Directed bench: ALU/branch checks, then mul/div ops scored through an expected-result queue.
module tb_riscv_alu_md;
  import riscv_alu_md_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] dataA, dataB;
  logic [3:0]  func;
  logic [2:0]  aluOp;
  logic        mdStart;
  logic [2:0]  mdOp;
  logic        flush;
  logic [31:0] aluResult;
  logic        branchFromAlu;
  logic        busy;
  logic        mdValid;
  logic [31:0] mdResult;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] sb[$];
  logic [31:0] last_res;
  int          vcnt;

  riscv_alu_md #(.WIDTH(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .dataA         (dataA),
    .dataB         (dataB),
    .func          (func),
    .aluOp         (aluOp),
    .mdStart       (mdStart),
    .mdOp          (mdOp),
    .flush         (flush),
    .aluResult     (aluResult),
    .branchFromAlu (branchFromAlu),
    .busy          (busy),
    .mdValid       (mdValid),
    .mdResult      (mdResult)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic alu_chk(input string tag, input logic [2:0] op, input logic [3:0] f,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    aluOp = op; func = f; dataA = a; dataB = b;
    #1 chk(tag, aluResult, exp);
  endtask

  task automatic br_chk(input string tag, input logic [3:0] f,
                        input logic [31:0] a, input logic [31:0] b, input logic exp);
    func = f; dataA = a; dataB = b;
    #1 chk(tag, {31'd0, branchFromAlu}, {31'd0, exp});
  endtask

  // Launch one op, optionally poke a start mid-flight, and score the result.
  task automatic md_run(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input bit poke);
    int          n;
    bit          busy_ok;
    logic [31:0] e;
    @(negedge clk);
    mdOp = op; dataA = a; dataB = b; mdStart = 1'b1;
    sb.push_back(exp);
    n = 0; busy_ok = 1'b1;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) mdStart = 1'b0;
      if (poke && n == 10) begin mdStart = 1'b1; mdOp = MD_DIVU; dataA = 32'h1234; dataB = 32'd3; end
      if (poke && n == 11) mdStart = 1'b0;
      if (!mdValid && !busy) busy_ok = 1'b0;
    end while (!mdValid && n < 100);
    chk({tag, "_valid"}, {31'd0, mdValid}, 32'd1);
    chk({tag, "_lat"}, n, 32'd34);
    chk({tag, "_busy"}, {31'd0, busy_ok}, 32'd1);
    e = (sb.size() != 0) ? sb.pop_front() : 32'hxxxxxxxx;
    chk({tag, "_res"}, mdResult, e);
    last_res = e;
    @(negedge clk);
    chk({tag, "_pulse"}, {31'd0, mdValid}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; dataA = '0; dataB = '0; func = '0; aluOp = '0;
    mdStart = 1'b0; mdOp = '0; flush = 1'b0;
    #3;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_valid", {31'd0, mdValid}, 32'd0);
    chk("rst_res", mdResult, 32'd0);
    @(negedge clk); reset = 1'b0;

    alu_chk("sra",    ALUOP_R, 4'hD, 32'h80000000, 32'd4, 32'hF8000000);
    alu_chk("sltu",   ALUOP_R, 4'h3, 32'hFFFFFFFF, 32'd1, 32'd0);
    alu_chk("slt",    ALUOP_R, 4'h2, 32'hFFFFFFFF, 32'd1, 32'd1);
    alu_chk("sub_r",  ALUOP_R, 4'h8, 32'd5, 32'd3, 32'd2);
    alu_chk("addi8",  ALUOP_I, 4'h8, 32'd5, 32'd3, 32'd8);
    alu_chk("srai",   ALUOP_I, 4'hD, 32'h80000000, 32'd36, 32'hF8000000);
    alu_chk("sll",    ALUOP_R, 4'h1, 32'h00000003, 32'd31, 32'h80000000);
    alu_chk("aluop_x", 3'b111, 4'h0, 32'd5, 32'd3, 32'd0);
    alu_chk("func_x", ALUOP_R, 4'h9, 32'd5, 32'd3, 32'd0);
    br_chk("bltu", 4'h6, 32'hFFFFFFFF, 32'd1, 1'b0);
    br_chk("blt",  4'h4, 32'hFFFFFFFF, 32'd1, 1'b1);
    br_chk("bge",  4'h5, 32'd7, 32'd7, 1'b1);
    br_chk("br2",  4'h2, 32'd7, 32'd7, 1'b0);

    md_run("mulh",   MD_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1);
    md_run("mulhu",  MD_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
    md_run("mul",    MD_MUL,    32'd12345,    32'hFFFFFFFE, 32'hFFFF9F8E, 1'b0);
    md_run("mulhsu", MD_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 1'b0);
    md_run("div_ov", MD_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0);
    md_run("rem_ov", MD_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0);
    md_run("divu_0", MD_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1'b0);
    md_run("remu_0", MD_REMU,   32'd5,        32'd0,        32'd5,        1'b0);
    md_run("rem_n",  MD_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0);
    md_run("div_n",  MD_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0);
    md_run("rem_0",  MD_REM,    32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 1'b0);

    // flush mid-divide
    @(negedge clk);
    mdOp = MD_DIV; dataA = 32'd100; dataB = 32'd7; mdStart = 1'b1;
    @(negedge clk); mdStart = 1'b0;
    repeat (8) @(negedge clk);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    chk("fl_busy", {31'd0, busy}, 32'd0);
    chk("fl_valid", {31'd0, mdValid}, 32'd0);
    vcnt = 0;
    repeat (40) begin @(negedge clk); if (mdValid) vcnt++; end
    chk("fl_novalid", vcnt, 32'd0);
    chk("fl_hold", mdResult, last_res);

    // start coincident with flush is dropped
    @(negedge clk); mdStart = 1'b1; flush = 1'b1;
    @(negedge clk); mdStart = 1'b0; flush = 1'b0;
    chk("fl_start", {31'd0, busy}, 32'd0);

    md_run("div_ok", MD_DIV, 32'd100, 32'd7, 32'd14, 1'b0);

    // async reset between edges mid-multiply
    @(negedge clk);
    mdOp = MD_MUL; dataA = 32'd3; dataB = 32'd5; mdStart = 1'b1;
    @(negedge clk); mdStart = 1'b0;
    repeat (5) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("ar_busy", {31'd0, busy}, 32'd0);
    chk("ar_valid", {31'd0, mdValid}, 32'd0);
    chk("ar_res", mdResult, 32'd0);
    @(negedge clk); reset = 1'b0;
    vcnt = 0;
    repeat (40) begin @(negedge clk); if (mdValid) vcnt++; end
    chk("ar_novalid", vcnt, 32'd0);
    chk("ar_idle", {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/riscv_alu_md.md
Name: riscv_alu_md

Overview:
- Parametrised successor to the single-cycle integer ALU.
- Combinational ALU path: full RV32I ALU op set (shifts, signed/unsigned compares) and all six branch conditions.
- Sequential iterative multiply/divide unit for the RV32M ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU), with start/busy/valid handshake and flush.
- Sits in the EX stage; the hazard unit stalls on busy.

Parameters:
- WIDTH, 32, datapath width; must be ≥8 and a power of two.
- SHAMT_W, $clog2(WIDTH), shift-amount bits taken from dataB.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- dataA  in  WIDTH  operand A (rs1).
- dataB  in  WIDTH  operand B (rs2 or immediate).
- func  in  4  {funct7[5], funct3}.
- aluOp  in  3  000 add, 001 sub, 010 R-type decode, 011 I-type decode.
- mdStart  in  1  launch mul/div; sampled only when busy=0.
- mdOp  in  3  funct3 of M op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- flush  in  1  abort any in-flight mul/div.
- aluResult  out  WIDTH  combinational ALU result.
- branchFromAlu  out  1  combinational branch-taken.
- busy  out  1  mul/div in progress.
- mdValid  out  1  one-cycle pulse: mdResult is valid.
- mdResult  out  WIDTH  registered mul/div result; held until next accepted start.

Behaviour:
- **ALU (combinational).**
  - aluOp 010: func 0 ADD, 8 SUB, 1 SLL, 2 SLT, 3 SLTU, 4 XOR, 5 SRL, D SRA, 6 OR, 7 AND.
  - aluOp 011: same decode, but func[3] is honoured only for func[2:0]=5 (SRAI); otherwise treated as 0 (ADDI, never SUB).
  - Shift amount = dataB[SHAMT_W-1:0].
  - SLT/SLTU yield 1 or 0, zero-extended.
  - Undefined aluOp or func → 0.
- **Branch (combinational, func[2:0]):** 0 EQ, 1 NE, 4 LT signed, 5 GE signed, 6 LTU, 7 GEU; 2 and 3 → 0.
- **Mul/div FSM states:** IDLE, CALC, DONE.
  - IDLE: mdStart=1 latches operands and op; counter=WIDTH; go to CALC. Signed ops take magnitudes, and the result sign is recorded.
  - CALC: one radix-2 step per cycle. Multiply is shift-add into a 2·WIDTH accumulator; divide is restoring shift-subtract. Counter decrements; at 0 go to DONE.
  - DONE: apply sign fix, register mdResult, pulse mdValid for one cycle, return to IDLE.
  - busy = (state != IDLE).
  - Latency: start accepted at edge N → mdValid high in the cycle after edge N+WIDTH+1 (WIDTH+2 cycles start-to-result). The next start may be accepted in the same cycle mdValid is high.
- **Result selection:** MUL = low WIDTH bits. MULH/MULHSU/MULHU = high WIDTH bits. MULHSU treats A as signed and B as unsigned.
- **Division special cases (no trap):**
  - Divide by zero → DIV/DIVU quotient all-ones; REM/REMU = dividend. These still take the full latency.
  - Signed overflow (A=MIN, B=-1) → DIV = MIN, REM = 0.
  - Remainder sign follows the dividend.
- **Start while busy:** ignored, with no effect on the in-flight op.
- **flush:** state → IDLE next edge; mdValid is not asserted; mdResult keeps its previous value. flush and mdStart in the same cycle: flush wins, start is dropped.
- **reset (async):** state=IDLE, busy=0, mdValid=0, mdResult=0, counter=0, accumulators=0. Reset asserted mid-operation abandons the op; no mdValid afterwards.

Decomposition:
- Shared package holds:
  - aluOp codes
  - func codes (ALU_ADD…ALU_SRA)
  - branch funct3 codes
  - mdOp codes
  - FSM state enum (IDLE/CALC/DONE).
- One sub-module, riscv_muldiv_iter: the FSM plus datapath. The top contains the combinational ALU and branch logic and instantiates it.

Test Plan:
- **ALU ops:** aluOp=010, func=D, A=0x80000000, B=4 → aluResult=0xF8000000; func=3, A=0xFFFFFFFF, B=1 → 0; func=2, same operands → 1.
- **Branches:** func=6, A=0xFFFFFFFF, B=1 → branchFromAlu=0; func=4, same operands → 1; func=5, A=B=7 → 1.
- **MULH / MULHU:** MULH, A=0xFFFFFFFF, B=0xFFFFFFFF → mdResult=0 and mdValid exactly 34 cycles after start; MULHU, same operands → 0xFFFFFFFE. busy stays high throughout; a start pulsed mid-op is ignored.
- **Division edge cases:** DIV A=0x80000000, B=0xFFFFFFFF → 0x80000000; REM, same operands → 0; DIVU A=5, B=0 → 0xFFFFFFFF; REMU A=5, B=0 → 5; REM A=-7, B=2 → 0xFFFFFFFF (-1).
- **Flush:** DIV 100/7 started, flush at cycle 10 → no mdValid, mdResult unchanged, busy=0 next cycle; a new DIV 100/7 afterwards → 14.
- **Async reset mid-MUL:** reset asserted between clock edges → busy, mdValid, mdResult are 0 immediately; no mdValid after release.
